ram_bus_arbiter: RTL and testbench

- Owns the shared asynchronous SRAM bank, which covers the contiguous 16MB RAM at address 0.
- Arbitrates that bank between the 68030 CPU and a secondary bus master (DMA/video fetch).
- Sequences chip-enable, output-enable and write-enable timing with a parameterised wait-state count.
- Terminates CPU cycles with 32-bit DSACK and drives the address/data mux select.
- Sits beside the ROM/overlay cycle logic in the glue CPLD; the external address decode supplies the RAM-select qualifier.

---
 rtl/ram_bus_arbiter_pkg.sv | 46 ++++
 rtl/ram_bus_arbiter_if.sv | 28 ++
 rtl/ram_bus_arbiter_lane_decode.sv | 12 +
 rtl/ram_bus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_ram_bus_arbiter.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/ram_bus_arbiter_pkg.sv
// Shared types and the byte-lane decode used by the SRAM bank arbiter.
// Lane n is byte offset n within the 32-bit word and maps to chip enable [3-n].
package ram_arb_pkg;

  typedef enum logic [2:0] {
    sIDLE     = 3'd0,
    sCPU_ACT  = 3'd1,
    sCPU_WAIT = 3'd2,
    sCPU_TERM = 3'd3,
    sDMA_ACT  = 3'd4,
    sDMA_WAIT = 3'd5,
    sDMA_DONE = 3'd6,
    sRECOV    = 3'd7
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  localparam logic [1:0] SIZ_LONG  = 2'd0;
  localparam logic [1:0] SIZ_BYTE  = 2'd1;
  localparam logic [1:0] SIZ_WORD  = 2'd2;
  localparam logic [1:0] SIZ_3BYTE = 2'd3;

  // Active-low CE mask for a write: lanes from A up to the operand end, clipped at lane 3.
  function automatic logic [3:0] lane_mask(input logic [1:0] siz, input logic [1:0] a);
    logic [2:0] lo;
    logic [2:0] hi;
    logic [3:0] ce_n;
    lo = {1'b0, a};
    case (siz)
      SIZ_BYTE:  hi = lo;
      SIZ_WORD:  hi = lo + 3'd1;
      SIZ_3BYTE: hi = lo + 3'd2;
      default:   hi = 3'd3;
    endcase
    if (hi > 3'd3) hi = 3'd3;
    ce_n = 4'hF;
    for (int n = 0; n < 4; n++) begin
      if ((3'(n) >= lo) && (3'(n) <= hi)) ce_n[3-n] = 1'b0;
    end
    return ce_n;
  endfunction

endpackage

// File: rtl/ram_bus_arbiter_if.sv
// Request/strobe bundle between the bus masters, the SRAM bank and the arbiter.
interface ram_bus_arbiter_if;

  logic       cpuReq;
  logic       cpuRnW;
  logic [1:0] cpuSiz;
  logic [1:0] cpuA;
  logic [1:0] nDsackRam;
  logic       dmaReq;
  logic       dmaRnW;
  logic       dmaGnt;
  logic       dmaDone;
  logic       busSel;
  logic [3:0] nRamCE;
  logic       nRamOE;
  logic       nRamWE;

  modport slave (
    input  cpuReq, cpuRnW, cpuSiz, cpuA, dmaReq, dmaRnW,
    output nDsackRam, dmaGnt, dmaDone, busSel, nRamCE, nRamOE, nRamWE
  );

  modport master (
    output cpuReq, cpuRnW, cpuSiz, cpuA, dmaReq, dmaRnW,
    input  nDsackRam, dmaGnt, dmaDone, busSel, nRamCE, nRamOE, nRamWE
  );

endinterface

// File: rtl/ram_bus_arbiter_lane_decode.sv
// Combinational wrapper around lane_mask so the write lane decode stands alone.
module ram_lane_decode
  import ram_arb_pkg::*;
(
  input  logic [1:0] i_siz,
  input  logic [1:0] i_a,
  output logic [3:0] o_ce_n
);

  assign o_ce_n = lane_mask(i_siz, i_a);

endmodule

// File: rtl/ram_bus_arbiter.sv
// SRAM bank arbiter between the 68030 and the secondary master: round-robin grant,
// wait-state sequenced CE/OE/WE, 32-bit DSACK termination and a forced recovery gap.
module ram_bus_arbiter
  import ram_arb_pkg::*;
#(
  parameter int WAIT_STATES  = 2,
  parameter int RECOV_CYCLES = 1
) (
  input  logic              sysClk,
  input  logic              reset,
  ram_bus_arbiter_if.slave  bus
);

  localparam logic [2:0] WS = 3'(WAIT_STATES);
  localparam logic [2:0] RC = 3'(RECOV_CYCLES);

  state_t     r_state;
  owner_t     r_last;
  logic [2:0] r_cnt;
  logic [1:0] r_dsack_n;
  logic       r_dma_gnt;
  logic       r_dma_done;
  logic       r_bus_sel;
  logic [3:0] r_ce_n;
  logic       r_oe_n;
  logic       r_we_n;

  logic [3:0] w_lane_ce_n;
  logic [3:0] w_cpu_ce_n;

  ram_lane_decode u_lane_decode (
    .i_siz  (bus.cpuSiz),
    .i_a    (bus.cpuA),
    .o_ce_n (w_lane_ce_n)
  );

  // Reads enable every lane; the CPU picks its bytes off the 32-bit bus.
  assign w_cpu_ce_n = bus.cpuRnW ? 4'h0 : w_lane_ce_n;

  assign bus.nDsackRam = r_dsack_n;
  assign bus.dmaGnt    = r_dma_gnt;
  assign bus.dmaDone   = r_dma_done;
  assign bus.busSel    = r_bus_sel;
  assign bus.nRamCE    = r_ce_n;
  assign bus.nRamOE    = r_oe_n;
  assign bus.nRamWE    = r_we_n;

  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      r_state    <= sIDLE;
      r_last     <= OWN_DMA;
      r_cnt      <= 3'd0;
      r_dsack_n  <= 2'b11;
      r_dma_gnt  <= 1'b0;
      r_dma_done <= 1'b0;
      r_bus_sel  <= 1'b0;
      r_ce_n     <= 4'hF;
      r_oe_n     <= 1'b1;
      r_we_n     <= 1'b1;
    end else begin
      case (r_state)
        sIDLE: begin
          if (bus.cpuReq && (!bus.dmaReq || (r_last == OWN_DMA))) begin
            r_state   <= sCPU_ACT;
            r_bus_sel <= 1'b0;
          end else if (bus.dmaReq) begin
            r_state   <= sDMA_ACT;
            r_dma_gnt <= 1'b1;
            r_bus_sel <= 1'b1;
          end
        end

        sCPU_ACT: begin
          if (!bus.cpuReq) begin
            r_state <= sRECOV;
            r_cnt   <= RC;
            r_ce_n  <= 4'hF;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
          end else begin
            r_ce_n  <= w_cpu_ce_n;
            r_oe_n  <= ~bus.cpuRnW;
            r_we_n  <= bus.cpuRnW;
            r_cnt   <= WS;
            r_state <= (WS == 3'd0) ? sCPU_TERM : sCPU_WAIT;
          end
        end

        sCPU_WAIT: begin
          if (!bus.cpuReq) begin
            r_state <= sRECOV;
            r_cnt   <= RC;
            r_ce_n  <= 4'hF;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
          end else if (r_cnt <= 3'd1) begin
            r_state <= sCPU_TERM;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end

        // WE is released as DSACK goes out so the write ends before the CPU moves on.
        sCPU_TERM: begin
          r_last <= OWN_CPU;
          if (bus.cpuReq) begin
            r_dsack_n <= 2'b00;
            r_we_n    <= 1'b1;
          end else begin
            r_state   <= sRECOV;
            r_cnt     <= RC;
            r_dsack_n <= 2'b11;
            r_ce_n    <= 4'hF;
            r_oe_n    <= 1'b1;
            r_we_n    <= 1'b1;
          end
        end

        sDMA_ACT: begin
          r_ce_n  <= 4'h0;
          r_oe_n  <= ~bus.dmaRnW;
          r_we_n  <= bus.dmaRnW;
          r_cnt   <= WS;
          r_state <= (WS == 3'd0) ? sDMA_DONE : sDMA_WAIT;
        end

        sDMA_WAIT: begin
          if (r_cnt <= 3'd1) r_state <= sDMA_DONE;
          else               r_cnt   <= r_cnt - 3'd1;
        end

        sDMA_DONE: begin
          r_dma_done <= 1'b1;
          r_we_n     <= 1'b1;
          r_last     <= OWN_DMA;
          r_cnt      <= RC;
          r_state    <= sRECOV;
        end

        // Bus select drops with the grant so the mux never points at an idle master.
        sRECOV: begin
          r_dsack_n  <= 2'b11;
          r_dma_gnt  <= 1'b0;
          r_dma_done <= 1'b0;
          r_bus_sel  <= 1'b0;
          r_ce_n     <= 4'hF;
          r_oe_n     <= 1'b1;
          r_we_n     <= 1'b1;
          if (r_cnt <= 3'd1) r_state <= sIDLE;
          else               r_cnt   <= r_cnt - 3'd1;
        end

        default: begin
          r_state    <= sRECOV;
          r_cnt      <= RC;
          r_dsack_n  <= 2'b11;
          r_dma_gnt  <= 1'b0;
          r_dma_done <= 1'b0;
          r_bus_sel  <= 1'b0;
          r_ce_n     <= 4'hF;
          r_oe_n     <= 1'b1;
          r_we_n     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Randomized bench for ram_bus_arbiter against a transaction-timeline reference model.
module tb_ram_bus_arbiter;
  import ram_arb_pkg::*;

  localparam int WS = 2;
  localparam int RC = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_bus_arbiter_if bus();

  ram_bus_arbiter #(.WAIT_STATES(WS), .RECOV_CYCLES(RC)) dut (
    .sysClk (clk),
    .reset  (rst),
    .bus    (bus.slave)
  );

  logic [1:0] ld_siz, ld_a;
  logic [3:0] ld_ce;
  ram_lane_decode u_ld (.i_siz(ld_siz), .i_a(ld_a), .o_ce_n(ld_ce));

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Lanes A .. A+len-1 of the 4-byte port, clipped at lane 3; lane n drives CE[3-n].
  function automatic logic [3:0] ref_mask(input int siz, input int a);
    int len;
    logic [3:0] m;
    len = (siz == 1) ? 1 : (siz == 2) ? 2 : (siz == 3) ? 3 : 4;
    m = 4'hF;
    for (int n = a; (n < a + len) && (n < 4); n++) m[3-n] = 1'b0;
    return m;
  endfunction

  function automatic logic [31:0] pack(input logic [1:0] dsack, input logic [3:0] ce,
                                       input logic oe, input logic we, input logic gnt,
                                       input logic done, input logic bsel);
    return {21'b0, dsack, ce, oe, we, gnt, done, bsel};
  endfunction

  function automatic logic [31:0] observed();
    return pack(bus.nDsackRam, bus.nRamCE, bus.nRamOE, bus.nRamWE,
                bus.dmaGnt, bus.dmaDone, bus.busSel);
  endfunction

  localparam logic [31:0] IDLE_VEC = {21'b0, 2'b11, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  // Model state: one transaction at a time, described by its edge timestamps.
  int   nxt;
  bit   last_dma;
  int   tx_kind;
  int   tk, tf, tt, td;
  bit   twr;
  logic [3:0] tmask;

  task automatic raise_cpu();
    bus.cpuReq = 1'b1;
    bus.cpuRnW = 1'($urandom_range(1));
    bus.cpuSiz = 2'($urandom_range(3));
    bus.cpuA   = 2'($urandom_range(3));
  endtask

  initial begin
    logic [31:0] exp;
    logic [1:0]  e_ds;
    logic [3:0]  e_ce;
    logic        e_oe, e_we, e_gnt, e_done, e_bs;
    int          pc, pd, x;
    bit          forced;

    rst = 1'b1;
    bus.cpuReq = 1'b0; bus.cpuRnW = 1'b1; bus.cpuSiz = SIZ_LONG; bus.cpuA = 2'd0;
    bus.dmaReq = 1'b0; bus.dmaRnW = 1'b1;
    ld_siz = 2'd0; ld_a = 2'd0;

    for (int s = 0; s < 4; s++) begin
      for (int a = 0; a < 4; a++) begin
        ld_siz = 2'(s);
        ld_a   = 2'(a);
        #1;
        check_eq($sformatf("lane_s%0d_a%0d", s, a), {28'b0, ld_ce}, {28'b0, ref_mask(s, a)});
      end
    end

    repeat (2) @(posedge clk);
    #1 check_eq("reset_state", observed(), IDLE_VEC);
    @(negedge clk) rst = 1'b0;

    // Long read, then reset lands while the access is in its wait states.
    bus.cpuReq = 1'b1; bus.cpuRnW = 1'b1; bus.cpuSiz = SIZ_LONG; bus.cpuA = 2'd0;
    repeat (3) @(posedge clk);
    #1 check_eq("pre_reset_wait", observed(), pack(2'b11, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    #1 rst = 1'b1;
    #1 check_eq("async_reset", observed(), IDLE_VEC);
    bus.dmaReq = 1'b1;
    @(negedge clk) rst = 1'b0;

    nxt = 1; last_dma = 1'b1; tx_kind = 0;
    tk = 0; tf = 0; tt = 0; td = 0; twr = 1'b0; tmask = 4'hF;

    for (int e = 0; e < 2600; e++) begin
      x = e + 1;
      forced = (e >= 1600) && (e < 2200);
      pc = forced ? 100 : (e < 1600) ? 35 : 60;
      pd = forced ? 100 : (e < 1600) ? 35 : 20;

      if (tx_kind == 1 && x <= tf) bus.cpuReq = (x < tf);
      else if (!bus.cpuReq && ($urandom_range(99) < pc)) raise_cpu();

      if (tx_kind == 2 && x <= td) begin
        bus.dmaReq = forced ? 1'b1 : 1'($urandom_range(1));
      end else begin
        if (!bus.dmaReq && ($urandom_range(99) < pd)) bus.dmaReq = 1'b1;
        bus.dmaRnW = 1'($urandom_range(1));
      end

      if (x >= nxt) begin
        if (bus.cpuReq && (!bus.dmaReq || last_dma)) begin
          tx_kind = 1; tk = x; tt = x + 2 + WS;
          if ($urandom_range(3) == 0) tf = x + 1 + $urandom_range(WS);
          else                        tf = tt + $urandom_range(3);
          twr   = !bus.cpuRnW;
          tmask = twr ? ref_mask(int'(bus.cpuSiz), int'(bus.cpuA)) : 4'h0;
          nxt   = tf + RC + 1;
          if (tf >= tt) last_dma = 1'b0;
        end else if (bus.dmaReq) begin
          tx_kind = 2; tk = x; td = x + 2 + WS;
          twr = !bus.dmaRnW;
          nxt = td + RC + 1;
          last_dma = 1'b1;
        end else begin
          nxt = x + 1;
        end
      end

      e_ds = 2'b11; e_ce = 4'hF; e_oe = 1'b1; e_we = 1'b1;
      e_gnt = 1'b0; e_done = 1'b0; e_bs = 1'b0;
      if (tx_kind == 1) begin
        if (x >= tk + 1 && x < tf) begin
          e_ce = tmask;
          e_oe = twr;
          e_we = (twr && x < ((tf < tt) ? tf : tt)) ? 1'b0 : 1'b1;
        end
        if (x >= tt && x < tf) e_ds = 2'b00;
      end else if (tx_kind == 2) begin
        if (x >= tk && x <= td) begin e_gnt = 1'b1; e_bs = 1'b1; end
        if (x >= tk + 1 && x <= td) begin
          e_ce = 4'h0;
          e_oe = twr;
          e_we = (twr && x < td) ? 1'b0 : 1'b1;
        end
        if (x == td) e_done = 1'b1;
      end
      exp = pack(e_ds, e_ce, e_oe, e_we, e_gnt, e_done, e_bs);

      @(posedge clk);
      #1 check_eq($sformatf("cyc%0d", x), observed(), exp);
    end

    bus.cpuReq = 1'b0;
    bus.dmaReq = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
